// File: rtl/and_inertial_rx.sv
// -----------------------------------------------------------------------------
// and_inertial_rx
//   Inertial (debounce-style) filter on the AND of two synchronous inputs.
//   `out` follows raw = in1 & in2 only after raw has differed from `out` on
//   DELAY consecutive rising edges. If raw reverts before then, the candidate
//   is dropped and counted as a glitch. Rise, fall and glitch events each
//   produce a one-cycle strobe and bump a saturating counter.
//
// Parameters
//   DELAY  edges a new value must hold before `out` follows it (1..255)
//   CW     width of each event counter
//
// Ports
//   clock         rising-edge clock for all state
//   reset_n       asynchronous active-low reset
//   in1, in2      operands, synchronous to clock
//   clear         synchronous clear of the three event counters
//   out           filtered, registered value of in1 & in2
//   pending       high while a candidate transition is being qualified
//   rise_pulse    one-cycle strobe after out goes 0->1
//   fall_pulse    one-cycle strobe after out goes 1->0
//   glitch_pulse  one-cycle strobe after a candidate is abandoned
//   rise_count, fall_count, glitch_count  saturating event counters
// -----------------------------------------------------------------------------
module and_inertial_rx #(
    parameter int DELAY = 10,
    parameter int CW    = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in1,
    input  logic          in2,
    input  logic          clear,
    output logic          out,
    output logic          pending,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic          glitch_pulse,
    output logic [CW-1:0] rise_count,
    output logic [CW-1:0] fall_count,
    output logic [CW-1:0] glitch_count
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // cnt counts edges already spent qualifying; the DELAY-th edge is the
    // one that sees cnt == DELAY-1 and commits the new value.
    localparam logic [7:0]    CNT_LAST = 8'(DELAY - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic          raw;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          pending_q, pending_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          glitch_q, glitch_d;
    logic [CW-1:0] rise_count_q, rise_count_d;
    logic [CW-1:0] fall_count_q, fall_count_d;
    logic [CW-1:0] glitch_count_q, glitch_count_d;

    assign raw = in1 & in2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (raw != out_q) begin
                    if (DELAY == 1) begin
                        // No qualification window: follow raw immediately.
                        out_d  = raw;
                        rise_d = raw;
                        fall_d = ~raw;
                    end else begin
                        state_d = PEND;
                        cnt_d   = 8'd1;
                    end
                end
            end
            PEND: begin
                if (raw == out_q) begin
                    // Candidate reverted before it qualified.
                    state_d  = IDLE;
                    cnt_d    = 8'd0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = raw;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    rise_d  = raw;
                    fall_d  = ~raw;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        pending_d = (state_d == PEND);

        // Counters saturate; clear overrides a same-edge increment.
        rise_count_d   = rise_count_q;
        fall_count_d   = fall_count_q;
        glitch_count_d = glitch_count_q;
        if (rise_d && rise_count_q != CNT_MAX)
            rise_count_d = rise_count_q + CW'(1);
        if (fall_d && fall_count_q != CNT_MAX)
            fall_count_d = fall_count_q + CW'(1);
        if (glitch_d && glitch_count_q != CNT_MAX)
            glitch_count_d = glitch_count_q + CW'(1);
        if (clear) begin
            rise_count_d   = '0;
            fall_count_d   = '0;
            glitch_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            out_q          <= 1'b0;
            pending_q      <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            glitch_q       <= 1'b0;
            rise_count_q   <= '0;
            fall_count_q   <= '0;
            glitch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            pending_q      <= pending_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            glitch_q       <= glitch_d;
            rise_count_q   <= rise_count_d;
            fall_count_q   <= fall_count_d;
            glitch_count_q <= glitch_count_d;
        end
    end

    assign out          = out_q;
    assign pending      = pending_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_pulse = glitch_q;
    assign rise_count   = rise_count_q;
    assign fall_count   = fall_count_q;
    assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_and_inertial_rx.sv
// -----------------------------------------------------------------------------
// tb_and_inertial_rx
//   Three filter instances share one clock and reset:
//     inst 0: DELAY=10, CW=8   inst 1: DELAY=1, CW=8   inst 2: DELAY=3, CW=2
//   Every clock edge the stimulus process advances an event-level reference
//   model (run length of raw != out) and queues the expected outputs; a
//   negedge monitor pops and compares. Directed scenarios add fixed-value
//   checks at the edges of interest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and_inertial_rx;

    typedef struct packed {
        logic       out, pend, rp, fp, gp;
        logic [7:0] rc, fc, gc;
        logic [7:0] run;
    } mdl_t;
    typedef mdl_t [2:0] exp_t;

    localparam int DLY [3] = '{10, 1, 3};
    localparam int MX  [3] = '{255, 255, 3};

    logic       clock;
    logic       reset_n;
    logic [2:0] i1, i2, cl;
    logic [2:0] o_out, o_pend, o_rp, o_fp, o_gp;
    logic [7:0] rc0, fc0, gc0, rc1, fc1, gc1;
    logic [1:0] rc2, fc2, gc2;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    mdl_t m [3];

    and_inertial_rx #(.DELAY(10), .CW(8)) u0 (
        .clock(clock), .reset_n(reset_n), .in1(i1[0]), .in2(i2[0]), .clear(cl[0]),
        .out(o_out[0]), .pending(o_pend[0]), .rise_pulse(o_rp[0]), .fall_pulse(o_fp[0]),
        .glitch_pulse(o_gp[0]), .rise_count(rc0), .fall_count(fc0), .glitch_count(gc0));
    and_inertial_rx #(.DELAY(1), .CW(8)) u1 (
        .clock(clock), .reset_n(reset_n), .in1(i1[1]), .in2(i2[1]), .clear(cl[1]),
        .out(o_out[1]), .pending(o_pend[1]), .rise_pulse(o_rp[1]), .fall_pulse(o_fp[1]),
        .glitch_pulse(o_gp[1]), .rise_count(rc1), .fall_count(fc1), .glitch_count(gc1));
    and_inertial_rx #(.DELAY(3), .CW(2)) u2 (
        .clock(clock), .reset_n(reset_n), .in1(i1[2]), .in2(i2[2]), .clear(cl[2]),
        .out(o_out[2]), .pending(o_pend[2]), .rise_pulse(o_rp[2]), .fall_pulse(o_fp[2]),
        .glitch_pulse(o_gp[2]), .rise_count(rc2), .fall_count(fc2), .glitch_count(gc2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    // Behavioural rule: out takes raw once raw has differed from out on
    // DELAY consecutive edges; a broken run of length > 0 is a glitch.
    function automatic mdl_t step(input mdl_t c, input logic raw, input logic clr,
                                  input int dly, input int mx);
        mdl_t n = c;
        int   run = int'(c.run);
        n.rp = 1'b0; n.fp = 1'b0; n.gp = 1'b0;
        if (raw != c.out) begin
            run++;
            if (run == dly) begin
                n.out = raw;
                n.rp  = raw;
                n.fp  = ~raw;
                run   = 0;
            end
        end else begin
            n.gp = (run != 0);
            run  = 0;
        end
        n.run  = 8'(run);
        n.pend = (run != 0);
        if (n.rp && int'(c.rc) < mx) n.rc = c.rc + 8'd1;
        if (n.fp && int'(c.fc) < mx) n.fc = c.fc + 8'd1;
        if (n.gp && int'(c.gc) < mx) n.gc = c.gc + 8'd1;
        if (clr) begin n.rc = '0; n.fc = '0; n.gc = '0; end
        return n;
    endfunction

    // One clock edge: advance the models with the held inputs, queue expectations.
    task automatic step_clk();
        exp_t e;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) m[i] = '0;
            else m[i] = step(m[i], i1[i] & i2[i], cl[i], DLY[i], MX[i]);
            e[i] = m[i];
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic cmp(input int i, input mdl_t e, input logic a_out, input logic a_pend,
                       input logic a_rp, input logic a_fp, input logic a_gp,
                       input logic [7:0] a_rc, input logic [7:0] a_fc, input logic [7:0] a_gc);
        chk("sb_out", i, a_out, e.out);
        chk("sb_pending", i, a_pend, e.pend);
        chk("sb_rise_pulse", i, a_rp, e.rp);
        chk("sb_fall_pulse", i, a_fp, e.fp);
        chk("sb_glitch_pulse", i, a_gp, e.gp);
        chk("sb_rise_count", i, a_rc, e.rc);
        chk("sb_fall_count", i, a_fc, e.fc);
        chk("sb_glitch_count", i, a_gc, e.gc);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(0, e[0], o_out[0], o_pend[0], o_rp[0], o_fp[0], o_gp[0], rc0, fc0, gc0);
            cmp(1, e[1], o_out[1], o_pend[1], o_rp[1], o_fp[1], o_gp[1], rc1, fc1, gc1);
            cmp(2, e[2], o_out[2], o_pend[2], o_rp[2], o_fp[2], o_gp[2],
                {6'd0, rc2}, {6'd0, fc2}, {6'd0, gc2});
        end
    end

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) m[i] = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out", i, o_out[i], 0);
            chk("rst_pending", i, o_pend[i], 0);
            chk("rst_pulses", i, {o_rp[i], o_fp[i], o_gp[i]}, 0);
        end
        chk("rst_counts", 0, {rc0, fc0, gc0}, 0);
        chk("rst_counts", 2, {rc2, fc2, gc2}, 0);
        step_clk();
        step_clk();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        logic r;
        reset_n = 1'b1;
        i1 = '0; i2 = '0; cl = '0;
        for (int i = 0; i < 3; i++) m[i] = '0;
        #2;
        apply_reset();

        // Rise qualification on inst 0: pending after edges 1..9, out after edge 10.
        i1[0] = 1'b1; i2[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step_clk();
            chk("rise_pending", k, o_pend[0], (k <= 9) ? 1 : 0);
            chk("rise_out", k, o_out[0], (k >= 10) ? 1 : 0);
            chk("rise_pulse", k, o_rp[0], (k == 10) ? 1 : 0);
        end
        chk("rise_count", 0, rc0, 1);

        // Five-cycle dropout from out=1: glitch, no fall.
        i1[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step_clk();
            chk("glitch_hold_out", k, o_out[0], 1);
        end
        i1[0] = 1'b1;
        step_clk();
        chk("glitch_pulse", 0, o_gp[0], 1);
        chk("glitch_pending", 0, o_pend[0], 0);
        step_clk();
        chk("glitch_pulse_off", 0, o_gp[0], 0);
        chk("glitch_count", 0, gc0, 1);
        chk("glitch_fall_count", 0, fc0, 0);

        // Sustained drop: fall after the 10th edge.
        i1[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step_clk();
            chk("fall_out", k, o_out[0], (k >= 10) ? 0 : 1);
            chk("fall_pulse", k, o_fp[0], (k == 10) ? 1 : 0);
        end
        chk("fall_count", 0, fc0, 1);

        // DELAY=1: out tracks raw one edge later, never glitches.
        i1[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i2[1] = ((k / 2) % 2 == 0);
            r = i1[1] & i2[1];
            step_clk();
            chk("d1_track", k, o_out[1], r);
        end
        chk("d1_glitch_count", 1, gc1, 0);

        // CW=2 saturation, then clear on the same edge as a 6th glitch.
        i1[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            i2[2] = 1'b1; step_clk();
            i2[2] = 1'b0; step_clk();
            chk("sat_glitch_count", k, gc2, (k < 3) ? k : 3);
        end
        i2[2] = 1'b1; step_clk();
        i2[2] = 1'b0; cl[2] = 1'b1; step_clk();
        chk("clr_glitch_count", 2, gc2, 0);
        chk("clr_glitch_pulse", 2, o_gp[2], 1);
        cl[2] = 1'b0;
        step_clk();

        // Reset in the middle of a rising qualification (cnt=6).
        i1[0] = 1'b1; i2[0] = 1'b1;
        repeat (6) step_clk();
        chk("pre_rst_pending", 0, o_pend[0], 1);
        apply_reset();
        chk("post_rst_glitch_count", 0, gc0, 0);
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            chk("restart_out", k, o_out[0], (k == 10) ? 1 : 0);
            chk("restart_glitch", k, o_gp[0], 0);
        end

        // Randomised run with held inputs and occasional clears.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, (i == 0) ? 11 : 4) == 0) begin
                    i1[i] = 1'($urandom_range(0, 3) != 0);
                    i2[i] = 1'($urandom_range(0, 3) != 0);
                end
                cl[i] = ($urandom_range(0, 39) == 0);
            end
            step_clk();
        end
        cl = '0;
        step_clk();
        @(negedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
